// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock, with valid/ready on both sides.
// Optional feature macro: BIN2BCD_BLANK_EN adds the out_blank leading-zero mask.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    in_bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_ovf
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]   out_blank
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] res_bcd_q, res_bcd_d;
    logic             res_ovf_q, res_ovf_d;

    logic [BCD_W-1:0] adj_bcd;
    logic [BCD_W-1:0] shift_bcd;
    logic [BIN_W-1:0] shift_bin;
    logic             shift_carry;

    function automatic logic [3:0] dabble(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;

    // Digit k is blank when it and every digit above it are zero; the ones digit always shows.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] b);
        logic z;
        logic [DIGITS-1:0] m;
        z = 1'b1;
        m = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            z    = z & (b[4*k +: 4] == 4'd0);
            m[k] = z;
        end
        return m;
    endfunction

    assign out_blank = blank_q;
`endif

    always_comb begin
        adj_bcd = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            adj_bcd[4*k +: 4] = dabble(bcd_q[4*k +: 4]);
        end
        // The bit shifted out of the top digit is a lost multiple of 10**DIGITS.
        {shift_carry, shift_bcd, shift_bin} = {adj_bcd, bin_q, 1'b0};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        res_bcd_d = res_bcd_q;
        res_ovf_d = res_ovf_q;
`ifdef BIN2BCD_BLANK_EN
        blank_d   = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = in_bin;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d = shift_bin;
                bcd_d = shift_bcd;
                ovf_d = ovf_q | shift_carry;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    res_bcd_d = shift_bcd;
                    res_ovf_d = ovf_q | shift_carry;
`ifdef BIN2BCD_BLANK_EN
                    blank_d   = blank_mask(shift_bcd);
`endif
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_bcd_q <= '0;
            res_ovf_q <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_bcd_q <= res_bcd_d;
            res_ovf_q <= res_ovf_d;
`ifdef BIN2BCD_BLANK_EN
            blank_q   <= blank_d;
`endif
        end
    end

    // Working shift registers are reloaded on every accept, so they carry no reset.
    always_ff @(posedge clk) begin
        bin_q <= bin_d;
        bcd_q <= bcd_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = res_bcd_q;
    assign out_ovf   = res_ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: default 14-bit/4-digit instance plus a 20-bit/6-digit streaming instance.
module tb_bin2bcd_seq;

    typedef struct {
        logic [63:0] bcd;
        logic        ovf;
        logic [63:0] blank;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_bad = 0;

    // Instance 1: defaults
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_ovf;
    logic [13:0] in_bin = '0;
    logic [15:0] out_bcd;
    logic [3:0]  out_blank;
    exp_t        q1[$];

    // Instance 2: BIN_W=20, DIGITS=6
    logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1, out_ovf2;
    logic [19:0] in_bin2 = '0;
    logic [23:0] out_bcd2;
    logic [5:0]  out_blank2;
    exp_t        q2[$];

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
        .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .out_ovf(out_ovf)
`ifdef BIN2BCD_BLANK_EN
        , .out_blank(out_blank)
`endif
    );

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_bin(in_bin2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_bcd(out_bcd2), .out_ovf(out_ovf2)
`ifdef BIN2BCD_BLANK_EN
        , .out_blank(out_blank2)
`endif
    );

`ifndef BIN2BCD_BLANK_EN
    assign out_blank  = '0;
    assign out_blank2 = '0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference model: decimal digits of v mod 10**d, overflow, leading-zero mask.
    function automatic exp_t model(input longint v, input int d, input int acc);
        exp_t   e;
        longint p = 1;
        longint m;
        int     nd;
        for (int i = 0; i < d; i++) p = p * 10;
        m       = v % p;
        e.ovf   = (v >= p);
        e.bcd   = '0;
        e.blank = '0;
        e.acc   = acc;
        nd      = 0;
        for (int k = 0; k < d; k++) begin
            e.bcd[4*k +: 4] = 4'(m % 10);
            if (m != 0) nd = k + 1;
            m = m / 10;
        end
        if (nd == 0) nd = 1;
        for (int k = 1; k < d; k++) e.blank[k] = (k >= nd);
        return e;
    endfunction

    task automatic send(input logic [13:0] v);
        bit ok = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_bin   = v;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                q1.push_back(model(longint'(v), 4, cyc + 1));
                ok = 1;
            end
        end
        if (!ok) note_fail("accept_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain1();
        for (int t = 0; t < 500 && q1.size() != 0; t++) @(negedge clk);
        if (q1.size() != 0) begin
            note_fail("drain_timeout");
            q1.delete();
        end
    endtask

    bit prev1 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) prev1 = 0;
        else begin
            if (out_valid && !prev1) begin
                if (q1.size() == 0) note_fail("spurious_out_valid");
                else chk("latency", 64'(cyc), 64'(q1[0].acc + 14));
            end
            if (out_valid && out_ready && q1.size() != 0) begin
                e = q1.pop_front();
                chk("out_bcd", 64'(out_bcd), e.bcd);
                chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
`ifdef BIN2BCD_BLANK_EN
                chk("out_blank", 64'(out_blank), e.blank);
`endif
            end
            prev1 = out_valid;
        end
    end

    bit prev2 = 0;
    int last_rise2 = -1;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) prev2 = 0;
        else begin
            if (out_valid2 && !prev2) begin
                if (q2.size() == 0) note_fail("spurious_out_valid2");
                else chk("latency2", 64'(cyc), 64'(q2[0].acc + 20));
                if (last_rise2 >= 0) chk("spacing2", 64'(cyc - last_rise2), 64'd22);
                last_rise2 = cyc;
            end
            if (out_valid2 && out_ready2 && q2.size() != 0) begin
                e = q2.pop_front();
                chk("out_bcd2", 64'(out_bcd2), e.bcd);
                chk("out_ovf2", 64'(out_ovf2), 64'(e.ovf));
`ifdef BIN2BCD_BLANK_EN
                chk("out_blank2", 64'(out_blank2), e.blank);
`endif
            end
            prev2 = out_valid2;
        end
    end

    initial begin
        exp_t   e;
        bit     rnd_done;
        bit     ok;
        longint vals2[3] = '{0, 999999, 1048575};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_bcd", 64'(out_bcd), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        chk("rst_out_blank", 64'(out_blank), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner values
        send(14'd9999);  drain1();
        send(14'd16383); drain1();
        send(14'd10000); drain1();
        send(14'd0);     drain1();
        send(14'd42);    drain1();

        // Back-pressure: result held 5 clocks, in_valid pulses ignored
        out_ready = 1'b0;
        send(14'd777);
        e  = model(64'd777, 4, 0);
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = out_valid;
        end
        if (!ok) note_fail("hold_wait_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_bcd", 64'(out_bcd), e.bcd);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            in_bin   = 14'd321;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("after_hs_out_bcd", 64'(out_bcd), e.bcd);
        drain1();

        // Reset in the middle of SHIFT
        send(14'd5678);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_bcd", 64'(out_bcd), 64'd0);
        chk("midrst_out_ovf", 64'(out_ovf), 64'd0);
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(14'd1234);
        drain1();

        // Random values under random back-pressure
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) send(14'($urandom_range(0, 16383)));
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain1();

        // Wide instance, continuous stream
        @(posedge clk); #1;
        in_bin2   = 20'(vals2[0]);
        in_valid2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ok = 0;
            for (int t = 0; t < 100 && !ok; t++) begin
                @(negedge clk);
                if (in_ready2) begin
                    q2.push_back(model(vals2[i], 6, cyc + 1));
                    ok = 1;
                end
            end
            if (!ok) note_fail("accept2_timeout");
            @(posedge clk); #1;
            if (i < 2) in_bin2 = 20'(vals2[i+1]);
            else in_valid2 = 1'b0;
        end
        for (int t = 0; t < 200 && q2.size() != 0; t++) @(negedge clk);
        if (q2.size() != 0) note_fail("drain2_timeout");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
